node_input_buffer: RTL and testbench
====================================

// Module: node_input_buffer
// PURPOSE
//  Per-port input FIFO placed between an incoming node_port link and one ports_down[] input of node.
//  Decouples link timing from crossbar arbitration by absorbing flits while node has not granted ack.
//  Also tracks packet framing (HEADER, BODY*, TAIL) and flags framing violations.
// PARAMETERS
//  DEPTH  4                  flit slots; power of two, >= 2
//  CNT_W  $clog2(DEPTH+1)    width of occupancy count (derived; do not override)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      reset, synchronous, active-low (asserted when 0)
//  link   node_port.down  -  upstream side: flit/enable in, ack out
//  out    node_port.up    -  downstream side (to node): flit/enable out, ack in
//  count  out  CNT_W  current occupancy, 0..DEPTH
//  err    out  1      sticky framing-violation flag
// BEHAVIOUR
//  - Transfer rule, both sides: a flit moves on a cycle where enable && ack, sampled at the clk edge.
//  - Push side: link.ack = (count != DEPTH). Driven from registered state only; no comb path from out.ack.
//    Full + pop in the same cycle: no push that cycle (ack already 0).
//  - Pop side: out.enable = (count != 0); out.flit = head entry.
//    While out.enable && !out.ack, out.flit is held stable.
//    node keeps ack high for the whole packet once granted; this block never withdraws enable mid-stall.
//  - Latency, bypass off: a flit pushed into an empty FIFO appears on out one cycle later.
//  - Simultaneous push and pop (0 < count < DEPTH): count unchanged; rd/wr pointers both advance.
//    Pointers wrap modulo DEPTH.
//  - Framing FSM on accepted pushes only:
//      OUTSIDE --HEADER--> INSIDE
//      INSIDE  --TAIL----> OUTSIDE
//      INSIDE  --BODY----> INSIDE
//    Violations: BODY or TAIL in OUTSIDE; HEADER in INSIDE.
//    On a violation: err <= 1 (sticky until reset). The flit is still stored and forwarded.
//    HEADER-in-INSIDE moves the FSM to INSIDE (new packet); BODY/TAIL-in-OUTSIDE leaves it OUTSIDE.
//  - Reset (rst==0 at edge), including mid-packet: pointers = 0, count = 0, FSM = OUTSIDE, err = 0.
//    Stored flits are discarded. Outputs then read: out.enable = 0, link.ack = 1, out.flit = '0.
//  - Non-enable cycles on link (enable == 0) are ignored regardless of flit contents.
// CONFIGURATION
//  - NODE_IBUF_BYPASS_EN defined:
//    When count == 0 and link.enable, out presents link.flit combinationally with out.enable = 1.
//    If out.ack is also 1 that cycle, the flit is consumed without being written (zero latency).
//    Otherwise it is written as normal.
//    The framing FSM and err update identically in both cases.
//  - Not defined: no comb path link -> out; minimum latency is 1 cycle.
// STRUCTURE
//  - Shared package (noc_pkg): flit_t, flit type enum (HEADER/BODY/TAIL), flit_hdr_t, addr_t, e_dir.
//    Add ibuf_frame_e {OUTSIDE, INSIDE} there.
//  - One sub-module: noc_fifo #(WIDTH, DEPTH): generic sync FIFO with push/pop/full/empty/count.
//    node_input_buffer adds the handshake mapping, the framing FSM and the bypass mux.
// TESTING
//  1. Reset, then push H, B, T with out.ack = 1
//     -> out.enable high one cycle after each push; same order; count peaks at 1; err = 0.
//  2. out.ack = 0; push 5 flits into DEPTH = 4
//     -> link.ack drops after the 4th accept; count = 4; 5th is held upstream.
//     Raise out.ack -> 4 pops in order, then 5th accepted.
//  3. count = 2, push and pop in the same cycle
//     -> count stays 2; output order preserved across pointer wrap (run 10 flits).
//  4. Push BODY while OUTSIDE -> err = 1 next cycle and stays 1.
//     HEADER, HEADER -> err = 1. Reset -> err = 0.
//  5. Reset asserted with 3 flits buffered mid-packet
//     -> next cycle count = 0, out.enable = 0, link.ack = 1.
//     A following HEADER gives no err.
//  6. With NODE_IBUF_BYPASS_EN, empty FIFO, link.enable and out.ack both 1
//     -> out.enable and out.flit equal link's in the same cycle; count stays 0.
//     Without the macro -> out.enable rises the next cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC flit, header and direction types, plus the input-buffer framing state.
package noc_pkg;
   localparam int DATA_W = 16;
   typedef logic [3:0] addr_t;
   typedef enum logic [2:0] {DIR_N, DIR_E, DIR_S, DIR_W, DIR_L} e_dir;
   typedef enum logic [1:0] {HEADER = 2'd0, BODY = 2'd1, TAIL = 2'd2} flit_type_e;
   typedef struct packed {
      addr_t      dst;
      addr_t      src;
      e_dir       dir;
      logic [4:0] rsvd;
   } flit_hdr_t;
   typedef struct packed {
      flit_type_e        kind;
      logic [DATA_W-1:0] data;
   } flit_t;
   typedef enum logic {OUTSIDE, INSIDE} ibuf_frame_e;
   function automatic flit_t mk_flit(flit_type_e k, logic [DATA_W-1:0] d);
      return '{kind: k, data: d};
   endfunction
endpackage

// File: rtl/node_port.sv
// node_port: flit/enable/ack link between NoC stages; down = receiving side, up = sending side.
interface node_port;
   logic           enable;
   noc_pkg::flit_t flit;
   logic           ack;
   modport down(input enable, input flit, output ack);
   modport up(output enable, output flit, input ack);
endinterface

// File: rtl/noc_fifo.sv
// noc_fifo: generic synchronous FIFO, power-of-two depth, active-low synchronous reset.
module noc_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;
   assign full    = count == CNT_W'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/node_input_buffer.sv
// node_input_buffer: per-port input FIFO with link handshake and packet-framing check.
// Define NODE_IBUF_BYPASS_EN for a zero-latency path from link to out when empty.
module node_input_buffer
   import noc_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   node_port.down           link,
   node_port.up             out,
   output logic [CNT_W-1:0] count,
   output logic             err
);
   logic        full, empty, push, pop, accept, viol;
   flit_t       head;
   ibuf_frame_e state, state_nxt;
   assign link.ack = !full;
   assign accept   = link.enable && !full;
   assign pop      = !empty && out.ack;
`ifdef NODE_IBUF_BYPASS_EN
   assign out.enable = !empty || link.enable;
   assign out.flit   = !empty ? head : link.enable ? link.flit : '0;
   // an empty buffer hands the flit straight through when node takes it this cycle
   assign push       = accept && !(empty && out.ack);
`else
   assign out.enable = !empty;
   assign out.flit   = !empty ? head : '0;
   assign push       = accept;
`endif
   noc_fifo #(.WIDTH($bits(flit_t)), .DEPTH(DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (link.flit),
      .dout (head),
      .full (full),
      .empty(empty),
      .count(count)
   );
   always_ff @(posedge clk)
      if (!rst) begin
         state <= OUTSIDE;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         err   <= err | viol;
      end
   always_comb
      state_nxt = !accept ? state :
                  link.flit.kind == HEADER ? INSIDE :
                  link.flit.kind == TAIL ? OUTSIDE : state;
   // a header is legal only outside a packet, body/tail only inside one
   always_comb
      viol = accept && ((state == OUTSIDE) != (link.flit.kind == HEADER));
endmodule

// File: tb/tb_node_input_buffer.sv
// tb_node_input_buffer: queue-model check of node_input_buffer with directed and random traffic.
module tb_node_input_buffer;
   import noc_pkg::*;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);
   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] count;
   logic             err;
   node_port link_if ();
   node_port out_if ();
   node_input_buffer #(.DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link_if),
      .out  (out_if),
      .count(count),
      .err  (err)
   );
   always #5 clk = ~clk;
   flit_t      q[$];
   bit         m_inside, m_err, armed, bypass, last_acc, pre_en;
   int         n_chk, n_bad;
   flit_type_e kinds[3] = '{HEADER, BODY, TAIL};
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic flit_t fl(flit_type_e k, int d);
      return mk_flit(k, d[15:0]);
   endfunction
   task automatic step(bit en, flit_t f, bit ack, bit rs);
      int    cnt;
      bit    e_en;
      flit_t e_fl;
      @(negedge clk);
      rst = rs;
      link_if.enable = en;
      link_if.flit = f;
      out_if.ack = ack;
      #1;
      cnt  = q.size();
      e_en = cnt != 0 || (bypass && en);
      e_fl = cnt != 0 ? q[0] : (bypass && en) ? f : '0;
      pre_en = out_if.enable;
      if (armed) begin
         chk("count", 32'(count), 32'(cnt));
         chk("link_ack", 32'(link_if.ack), 32'(cnt != DEPTH));
         chk("out_enable", 32'(out_if.enable), 32'(e_en));
         chk("out_flit", 32'(out_if.flit), 32'(e_fl));
         chk("err", 32'(err), 32'(m_err));
      end
      @(posedge clk);
      last_acc = 1'b0;
      if (!rs) begin
         q.delete();
         m_inside = 1'b0;
         m_err = 1'b0;
         armed = 1'b1;
      end else begin
         last_acc = en && cnt != DEPTH;
         if (last_acc) begin
            if (!m_inside && f.kind != HEADER) m_err = 1'b1;
            if (m_inside && f.kind == HEADER) m_err = 1'b1;
            m_inside = f.kind == HEADER ? 1'b1 : f.kind == TAIL ? 1'b0 : m_inside;
         end
         if (!(cnt == 0 && bypass && last_acc && ack)) begin
            if (ack && cnt != 0) void'(q.pop_front());
            if (last_acc) q.push_back(f);
         end
      end
   endtask
   task automatic idle(int n, bit ack);
      for (int i = 0; i < n; i++) step(1'b0, '0, ack, 1'b1);
   endtask
   initial begin
`ifdef NODE_IBUF_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      rst = 1'b0;
      link_if.enable = 1'b0;
      link_if.flit = '0;
      out_if.ack = 1'b0;
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_link_ack", 32'(link_if.ack), 32'd1);
      chk("rst_out_enable", 32'(out_if.enable), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      step(1'b1, fl(HEADER, 'h11), 1'b1, 1'b1);
      #1;
      chk("t1_enable_next", 32'(out_if.enable), 32'(!bypass));
      step(1'b1, fl(BODY, 'h12), 1'b1, 1'b1);
      step(1'b1, fl(TAIL, 'h13), 1'b1, 1'b1);
      #1;
      chk("t1_count_peak", 32'(count <= 1), 32'd1);
      idle(2, 1'b1);
      #1;
      chk("t1_err", 32'(err), 32'd0);
      step(1'b1, fl(HEADER, 'h21), 1'b0, 1'b1);
      step(1'b1, fl(BODY, 'h22), 1'b0, 1'b1);
      step(1'b1, fl(BODY, 'h23), 1'b0, 1'b1);
      step(1'b1, fl(BODY, 'h24), 1'b0, 1'b1);
      #1;
      chk("t2_full_count", 32'(count), 32'd4);
      chk("t2_full_ack", 32'(link_if.ack), 32'd0);
      step(1'b1, fl(TAIL, 'h25), 1'b0, 1'b1);
      #1;
      chk("t2_held_count", 32'(count), 32'd4);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, fl(TAIL, 'h25), 1'b1, 1'b1);
         if (last_acc) break;
      end
      chk("t2_fifth_accepted", 32'(last_acc), 32'd1);
      idle(5, 1'b1);
      step(1'b1, fl(HEADER, 'h31), 1'b0, 1'b1);
      step(1'b1, fl(BODY, 'h32), 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, fl(i == 9 ? TAIL : BODY, 'h40 + i), 1'b1, 1'b1);
      #1;
      chk("t3_count_steady", 32'(count), 32'd2);
      idle(3, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, fl(BODY, 'h51), 1'b1, 1'b1);
      #1;
      chk("t4_body_outside", 32'(err), 32'd1);
      idle(2, 1'b1);
      #1;
      chk("t4_sticky", 32'(err), 32'd1);
      step(1'b0, '0, 1'b1, 1'b0);
      #1;
      chk("t4_reset_clears", 32'(err), 32'd0);
      step(1'b1, fl(HEADER, 'h52), 1'b1, 1'b1);
      step(1'b1, fl(HEADER, 'h53), 1'b1, 1'b1);
      #1;
      chk("t4_double_header", 32'(err), 32'd1);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, fl(HEADER, 'h61), 1'b0, 1'b1);
      step(1'b1, fl(BODY, 'h62), 1'b0, 1'b1);
      step(1'b1, fl(BODY, 'h63), 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_out_enable", 32'(out_if.enable), 32'd0);
      chk("t5_link_ack", 32'(link_if.ack), 32'd1);
      step(1'b1, fl(HEADER, 'h64), 1'b1, 1'b1);
      step(1'b1, fl(TAIL, 'h65), 1'b1, 1'b1);
      idle(2, 1'b1);
      #1;
      chk("t5_header_no_err", 32'(err), 32'd0);
      step(1'b1, fl(HEADER, 'h71), 1'b1, 1'b1);
      chk("t6_same_cycle_enable", 32'(pre_en), 32'(bypass));
      #1;
      chk("t6_next_cycle_enable", 32'(out_if.enable), 32'(!bypass));
      step(1'b1, fl(TAIL, 'h72), 1'b1, 1'b1);
      idle(2, 1'b1);
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 1)), fl(kinds[$urandom_range(0, 2)], int'($urandom)),
              1'($urandom_range(0, 3) != 0 && (i % 64) > 8), 1'($urandom_range(0, 80) != 0));
      idle(6, 1'b1);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
